// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_fifo : 8N1/8E1/8O1/8x2 UART transmitter with byte FIFO       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Tx_DV,
  input  logic [7:0]                    i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done
);

  localparam int          c_AW        = $clog2(FIFO_DEPTH);
  localparam int          c_CW        = c_AW + 1;
  localparam logic [15:0] c_LAST_CLK  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  c_LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic        c_PEN       = (PARITY_EN != 0);
  localparam logic        c_ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_idx;
  logic [15:0]     r_clk_cnt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_bit_end;

  assign w_full       = (r_count == c_CW'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_push       = i_Tx_DV && !w_full;
  assign w_pop        = (r_state == S_IDLE) && !w_empty;
  assign w_bit_end    = (r_clk_cnt == c_LAST_CLK);
  assign o_Tx_Ready   = !w_full;
  assign o_Fifo_Count = r_count;

  always_ff @(posedge i_Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_Tx_Byte;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Line outputs are driven from the state seen at each edge, so the line
  // trails the state register by one cycle; Done fires on the first idle
  // cycle after an active frame.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_clk_cnt   <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      r_clk_cnt <= w_bit_end ? 16'd0 : r_clk_cnt + 16'd1;
      case (r_state)
        S_IDLE: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          o_Tx_Done   <= o_Tx_Active;
          r_clk_cnt   <= '0;
          if (!w_empty) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_bit_idx <= '0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          o_Tx_Serial <= 1'b0;
          o_Tx_Active <= 1'b1;
          if (w_bit_end) r_state <= S_DATA;
        end
        S_DATA: begin
          o_Tx_Serial <= r_shift[r_bit_idx];
          o_Tx_Active <= 1'b1;
          if (w_bit_end) begin
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= c_PEN ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          o_Tx_Serial <= (^r_shift) ^ c_ODD;
          o_Tx_Active <= 1'b1;
          if (w_bit_end) r_state <= S_STOP;
        end
        S_STOP: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b1;
          if (w_bit_end) begin
            if (r_bit_idx == c_LAST_STOP) begin
              r_bit_idx <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_fifo : checks four uart_tx_fifo configurations            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_tx_fifo;

  localparam int NI = 4;
  localparam int CPB   [NI] = '{4, 4, 4, 87};
  localparam int PEN   [NI] = '{0, 1, 1, 0};
  localparam int PODD  [NI] = '{0, 0, 1, 0};
  localparam int STOPB [NI] = '{1, 2, 1, 1};

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] dv;
  logic [7:0]    tx_byte [NI];
  wire  [NI-1:0] ready;
  wire  [NI-1:0] serial;
  wire  [NI-1:0] active;
  wire  [NI-1:0] done;
  wire  [2:0]    count [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_fifo #(
      .CLKS_PER_BIT(CPB[g]),
      .FIFO_DEPTH  (4),
      .PARITY_EN   (PEN[g]),
      .PARITY_ODD  (PODD[g]),
      .STOP_BITS   (STOPB[g])
    ) u_dut (
      .i_Clock     (clk),
      .i_Reset     (rst),
      .i_Tx_DV     (dv[g]),
      .i_Tx_Byte   (tx_byte[g]),
      .o_Tx_Ready  (ready[g]),
      .o_Fifo_Count(count[g]),
      .o_Tx_Serial (serial[g]),
      .o_Tx_Active (active[g]),
      .o_Tx_Done   (done[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] b);
    dv[k]      = 1'b1;
    tx_byte[k] = b;
    tick();
    dv[k]      = 1'b0;
  endtask

  // Reference frame: start, 8 data bits LSB first, optional parity, stop bits.
  function automatic void frame_bits(input int k, input logic [7:0] b,
                                     output logic [12:0] bits, output int n);
    bits    = '1;
    n       = 0;
    bits[n] = 1'b0;
    n++;
    for (int i = 0; i < 8; i++) begin
      bits[n] = b[i];
      n++;
    end
    if (PEN[k] != 0) begin
      bits[n] = (^b) ^ (PODD[k] != 0);
      n++;
    end
    for (int s = 0; s < STOPB[k]; s++) begin
      bits[n] = 1'b1;
      n++;
    end
  endfunction

  // Entered on frame cycle 'skip'; returns positioned on the Done cycle.
  task automatic check_frame(input int k, input logic [7:0] b, input int skip);
    logic [12:0] bits;
    int          n;
    logic [2:0]  want;
    frame_bits(k, b, bits, n);
    for (int c = skip; c < n * CPB[k]; c++) begin
      want = {bits[c / CPB[k]], 1'b1, 1'b0};
      checks++;
      if ({serial[k], active[k], done[k]} !== want) begin
        errors++;
        $display("FAIL frame k=%0d byte=%h cycle=%0d line/active/done got %b want %b",
                 k, b, c, {serial[k], active[k], done[k]}, want);
      end
      tick();
    end
    checks++;
    if ({serial[k], active[k], done[k]} !== 3'b101) begin
      errors++;
      $display("FAIL done_cycle k=%0d byte=%h line/active/done got %b want 101",
               k, b, {serial[k], active[k], done[k]});
    end
  endtask

  task automatic follow_frames(input int k, input logic [7:0] q [$], input int skip0);
    int want_cnt;
    for (int j = 0; j < q.size(); j++) begin
      check_frame(k, q[j], (j == 0) ? skip0 : 0);
      want_cnt = (q.size() - j - 2 > 0) ? q.size() - j - 2 : 0;
      checks++;
      if (count[k] !== 3'(want_cnt)) begin
        errors++;
        $display("FAIL count_after_frame k=%0d frame=%0d got %0d want %0d",
                 k, j, count[k], want_cnt);
      end
      tick();
    end
    checks++;
    if ({serial[k], active[k], done[k]} !== 3'b100) begin
      errors++;
      $display("FAIL idle_after k=%0d line/active/done got %b want 100",
               k, {serial[k], active[k], done[k]});
    end
  endtask

  // Writes on consecutive edges into an idle, empty transmitter, then
  // checks the two-cycle start latency and every following frame.
  task automatic send_burst(input int k, input logic [7:0] q [$]);
    int idx;
    foreach (q[i]) push(k, q[i]);
    idx = q.size() - 3;
    while (idx < 0) begin
      checks++;
      if ({serial[k], active[k], done[k]} !== 3'b100) begin
        errors++;
        $display("FAIL latency k=%0d offset=%0d line/active/done got %b want 100",
                 k, idx, {serial[k], active[k], done[k]});
      end
      tick();
      idx++;
    end
    follow_frames(k, q, idx);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dv  = '0;
    foreach (tx_byte[i]) tx_byte[i] = 8'h00;
    repeat (3) tick();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({serial[k], active[k], done[k], ready[k], count[k]} !== 7'b1001_000) begin
        errors++;
        $display("FAIL reset_held k=%0d got %b want 1001000",
                 k, {serial[k], active[k], done[k], ready[k], count[k]});
      end
    end
    rst = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({serial[k], active[k], done[k], ready[k], count[k]} !== 7'b1001_000) begin
        errors++;
        $display("FAIL reset_release k=%0d got %b want 1001000",
                 k, {serial[k], active[k], done[k], ready[k], count[k]});
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] q [$];
    q.push_back(8'hA5);
    send_burst(0, q);
  endtask

  task automatic test_parity();
    logic [7:0] q [$];
    q = {}; q.push_back(8'hA5); send_burst(1, q);
    q = {}; q.push_back(8'h01); send_burst(1, q);
    q = {}; q.push_back(8'hA5); send_burst(2, q);
    q = {}; q.push_back(8'h01); send_burst(2, q);
  endtask

  task automatic test_fifo_fill();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] q [$];
    push(0, 8'h10);
    tick();
    checks++;
    if (count[0] !== 3'd0) begin
      errors++;
      $display("FAIL fill_first_pop got %0d want 0", count[0]);
    end
    q.push_back(8'h10);
    for (int i = 0; i < 4; i++) begin
      push(0, vals[i]);
      q.push_back(vals[i]);
      checks++;
      if ({ready[0], count[0]} !== {(i < 3), 3'(i + 1)}) begin
        errors++;
        $display("FAIL fill_step i=%0d ready/count got %b want %b",
                 i, {ready[0], count[0]}, {(i < 3), 3'(i + 1)});
      end
    end
    push(0, 8'h55);
    checks++;
    if ({ready[0], count[0]} !== 4'b0100) begin
      errors++;
      $display("FAIL fill_drop ready/count got %b want 0100", {ready[0], count[0]});
    end
    follow_frames(0, q, 4);
  endtask

  task automatic test_reset_mid();
    logic [7:0] q [$];
    push(0, 8'h0F);
    push(0, 8'hAA);
    push(0, 8'hBB);
    checks++;
    if (count[0] !== 3'd2) begin
      errors++;
      $display("FAIL mid_pre_count got %0d want 2", count[0]);
    end
    repeat (8) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({serial[0], active[0], done[0], ready[0], count[0]} !== 7'b1001_000) begin
      errors++;
      $display("FAIL mid_reset_async got %b want 1001000",
               {serial[0], active[0], done[0], ready[0], count[0]});
    end
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      checks++;
      if ({serial[0], active[0], done[0], count[0]} !== 6'b100_000) begin
        errors++;
        $display("FAIL mid_quiet cycle=%0d got %b want 100000",
                 c, {serial[0], active[0], done[0], count[0]});
      end
      tick();
    end
    q.push_back(8'h81);
    send_burst(0, q);
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    int         b;
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 5; r++) begin
        repeat ($urandom_range(0, 3)) tick();
        b = $urandom_range(1, 4);
        q = {};
        for (int i = 0; i < b; i++) q.push_back(8'($urandom));
        send_burst(k, q);
      end
    end
  endtask

  // Independent receiver: finds each start edge and samples at bit centres.
  task automatic test_back_to_back();
    logic [7:0] sent [4] = '{8'h00, 8'hFF, 8'h3C, 8'hA5};
    logic [7:0] rx;
    int         waited;
    for (int i = 0; i < 4; i++) push(3, sent[i]);
    for (int j = 0; j < 4; j++) begin
      waited = 0;
      while (serial[3] !== 1'b0 && waited < 4 * CPB[3]) begin
        tick();
        waited++;
      end
      checks++;
      if (serial[3] !== 1'b0) begin
        errors++;
        $display("FAIL rx_start_timeout frame=%0d waited %0d want line 0", j, waited);
      end
      repeat (CPB[3] / 2) tick();
      checks++;
      if (serial[3] !== 1'b0) begin
        errors++;
        $display("FAIL rx_start_mid frame=%0d got %b want 0", j, serial[3]);
      end
      for (int i = 0; i < 8; i++) begin
        repeat (CPB[3]) tick();
        rx[i] = serial[3];
      end
      repeat (CPB[3]) tick();
      checks++;
      if (serial[3] !== 1'b1) begin
        errors++;
        $display("FAIL rx_stop frame=%0d got %b want 1", j, serial[3]);
      end
      checks++;
      if (rx !== sent[j]) begin
        errors++;
        $display("FAIL rx_byte frame=%0d got %h want %h", j, rx, sent[j]);
      end
    end
    repeat (2 * CPB[3]) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_fifo_fill();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
